// File: rtl/jtkiwi_gfxrom_pkg.sv
// jtkiwi_gfxrom_pkg: shared types and widths for the Kiwi gfx ROM responder.
//   state_e  : fetch FSM states
//   client_e : client select (scroll / object)
//   rom_addr : client word address -> SDRAM 16-bit word address (modulo 2^21)
package jtkiwi_gfxrom_pkg;
  localparam int AW  = 18;  // client 32-bit word address width
  localparam int SAW = 21;  // SDRAM 16-bit word address width
  localparam int DW  = 32;  // client data width

  typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_e;
  typedef enum logic {CL_SCR = 1'b0, CL_OBJ = 1'b1} client_e;

  // Each 32-bit client word is two 16-bit SDRAM words; the add wraps.
  function automatic logic [SAW-1:0] rom_addr(input logic [SAW-1:0] off,
                                              input logic [AW-1:0]  a);
    return off + {{(SAW-AW-1){1'b0}}, a, 1'b0};
  endfunction
endpackage

// File: rtl/jtkiwi_gfxrom_if.sv
// jtkiwi_gfxrom_if: bundle of the two client ports and the SDRAM read port.
//   master : the gfx pipeline + SDRAM controller side (drives addr/cs, gnt/rdy/din)
//   slave  : the ROM responder (drives data/ok, sdram_addr/req)
interface jtkiwi_gfxrom_if;
  import jtkiwi_gfxrom_pkg::*;
  logic [AW-1:0]  scr_addr;
  logic           scr_cs;
  logic [DW-1:0]  scr_data;
  logic           scr_ok;
  logic [AW-1:0]  obj_addr;
  logic           obj_cs;
  logic [DW-1:0]  obj_data;
  logic           obj_ok;
  logic [SAW-1:0] sdram_addr;
  logic           sdram_req;
  logic           sdram_gnt;
  logic           sdram_rdy;
  logic [15:0]    sdram_din;

  modport master(output scr_addr, scr_cs, obj_addr, obj_cs, sdram_gnt, sdram_rdy, sdram_din,
                 input  scr_data, scr_ok, obj_data, obj_ok, sdram_addr, sdram_req);
  modport slave (input  scr_addr, scr_cs, obj_addr, obj_cs, sdram_gnt, sdram_rdy, sdram_din,
                 output scr_data, scr_ok, obj_data, obj_ok, sdram_addr, sdram_req);
endinterface

// File: rtl/jtkiwi_gfxrom_line.sv
// jtkiwi_gfxrom_line: one cached 32-bit word (tag/valid/data) plus registered ok.
//   addr/cs  : client lookup            wr/wr_tag/wr_data : line write
//   inv      : clear valid (wr wins)    data  : cached word
//   match    : valid & tag==addr (comb) ok    : registered hit flag
module jtkiwi_gfxrom_line
  import jtkiwi_gfxrom_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          wr,
  input  logic [AW-1:0] wr_tag,
  input  logic [DW-1:0] wr_data,
  input  logic          inv,
  output logic [DW-1:0] data,
  output logic          match,
  output logic          ok
);
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d, ok_q, ok_d;

  assign match = valid_q & (tag_q == addr);
  assign data  = data_q;
  assign ok    = ok_q;

  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (wr) begin
      tag_d   = wr_tag;
      data_d  = wr_data;
      valid_d = 1'b1;
    end else if (inv) begin
      valid_d = 1'b0;
    end
    // A write lands in the same edge as ok, so compare against the new tag.
    ok_d = cs & (wr ? (wr_tag == addr) : match);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ok_q    <= ok_d;
    end
  end
endmodule

// File: rtl/jtkiwi_gfxrom.sv
// jtkiwi_gfxrom: gfx ROM responder for the scroll and object clients.
// One cached word per client; a miss fetches a two-beat 16-bit burst from SDRAM.
//   clk, rst : clock, async active-high reset
//   bus      : jtkiwi_gfxrom_if.slave (client addr/cs/data/ok, SDRAM addr/req/gnt/rdy/din)
// Optional: JTKIWI_GFXROM_PREFETCH_EN adds a per-client prefetch line that is
// filled with tag+1 of the last filled client while the FSM is otherwise idle.
module jtkiwi_gfxrom
  import jtkiwi_gfxrom_pkg::*;
#(
  parameter logic [SAW-1:0] SCR_OFFSET = 21'h00000,
  parameter logic [SAW-1:0] OBJ_OFFSET = 21'h80000
)(
  input logic             clk,
  input logic             rst,
  jtkiwi_gfxrom_if.slave  bus
);
  state_e         state_q, state_d;
  client_e        sel_q, sel_d, pri_q, pri_d;  // pri: winner of the next double miss
  logic [AW-1:0]  alat_q, alat_d;
  logic [SAW-1:0] saddr_q, saddr_d;
  logic [15:0]    stage_q, stage_d;
  logic           fill, pf_fetch;
  logic [DW-1:0]  fill_data;

  logic [1:0][AW-1:0] addr, wr_tag;
  logic [1:0][DW-1:0] data, wr_data, pdata;
  logic [1:0]         cs, match, pmatch, phit, miss, wr, ok;

`ifdef JTKIWI_GFXROM_PREFETCH_EN
  logic          pf_q, pf_d, pend_q, pend_d;
  client_e       pcl_q, pcl_d;
  logic [AW-1:0] ptag_q, ptag_d;
  logic [1:0]    pok;
  assign pf_fetch = pf_q;
`else
  assign pf_fetch = 1'b0;
`endif

  assign addr[CL_SCR] = bus.scr_addr;
  assign addr[CL_OBJ] = bus.obj_addr;
  assign cs[CL_SCR]   = bus.scr_cs;
  assign cs[CL_OBJ]   = bus.obj_cs;
  assign fill_data    = {bus.sdram_din, stage_q};

  for (genvar c = 0; c < 2; c++) begin : g_cl
    logic fill_main;
    assign fill_main  = fill & (sel_q == client_e'(c)) & ~pf_fetch;
    // Prefetch hits are copied into the main line tagged with the client addr.
    assign wr[c]      = fill_main | phit[c];
    assign wr_tag[c]  = fill_main ? alat_q : addr[c];
    assign wr_data[c] = fill_main ? fill_data : pdata[c];
    assign miss[c]    = cs[c] & ~match[c] & ~pmatch[c];

    jtkiwi_gfxrom_line u_main (
      .clk, .rst, .addr(addr[c]), .cs(cs[c]), .wr(wr[c]), .wr_tag(wr_tag[c]),
      .wr_data(wr_data[c]), .inv(1'b0), .data(data[c]), .match(match[c]), .ok(ok[c])
    );
`ifdef JTKIWI_GFXROM_PREFETCH_EN
    assign phit[c] = cs[c] & ~match[c] & pmatch[c] & ~fill_main;
    jtkiwi_gfxrom_line u_pf (
      .clk, .rst, .addr(addr[c]), .cs(cs[c]),
      .wr(fill & (sel_q == client_e'(c)) & pf_q), .wr_tag(alat_q), .wr_data(fill_data),
      .inv(phit[c]), .data(pdata[c]), .match(pmatch[c]), .ok(pok[c])
    );
`else
    assign phit[c]   = 1'b0;
    assign pmatch[c] = 1'b0;
    assign pdata[c]  = '0;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= CL_SCR;
      pri_q   <= CL_SCR;
      alat_q  <= '0;
      saddr_q <= '0;
      stage_q <= '0;
`ifdef JTKIWI_GFXROM_PREFETCH_EN
      pf_q    <= 1'b0;
      pend_q  <= 1'b0;
      pcl_q   <= CL_SCR;
      ptag_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pri_q   <= pri_d;
      alat_q  <= alat_d;
      saddr_q <= saddr_d;
      stage_q <= stage_d;
`ifdef JTKIWI_GFXROM_PREFETCH_EN
      pf_q    <= pf_d;
      pend_q  <= pend_d;
      pcl_q   <= pcl_d;
      ptag_q  <= ptag_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pri_d   = pri_q;
    alat_d  = alat_q;
    saddr_d = saddr_q;
    stage_d = stage_q;
`ifdef JTKIWI_GFXROM_PREFETCH_EN
    pf_d    = pf_q;
    pend_d  = pend_q;
    pcl_d   = pcl_q;
    ptag_d  = ptag_q;
`endif
    case (state_q)
      IDLE: begin
        if (|miss) begin
          if (&miss) begin
            sel_d = pri_q;
            pri_d = client_e'(~pri_q);
          end else begin
            sel_d = miss[CL_SCR] ? CL_SCR : CL_OBJ;
          end
          alat_d  = addr[sel_d];
          state_d = REQ;
`ifdef JTKIWI_GFXROM_PREFETCH_EN
          pf_d    = 1'b0;
        end else if (pend_q) begin
          sel_d   = pcl_q;
          alat_d  = ptag_q + AW'(1);
          pf_d    = 1'b1;
          pend_d  = 1'b0;
          state_d = REQ;
`endif
        end
        saddr_d = (state_d == REQ)
                ? rom_addr((sel_d == CL_SCR) ? SCR_OFFSET : OBJ_OFFSET, alat_d) : saddr_q;
      end
      REQ:   if (bus.sdram_gnt) state_d = BEAT0;
      BEAT0: if (bus.sdram_rdy) begin
        stage_d = bus.sdram_din;
        state_d = BEAT1;
      end
      BEAT1: if (bus.sdram_rdy) begin
        state_d = IDLE;
`ifdef JTKIWI_GFXROM_PREFETCH_EN
        if (!pf_q) begin
          pend_d = 1'b1;
          pcl_d  = sel_q;
          ptag_d = alat_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    fill           = (state_q == BEAT1) & bus.sdram_rdy;
    bus.sdram_req  = (state_q == REQ);
    bus.sdram_addr = saddr_q;
    bus.scr_data   = data[CL_SCR];
    bus.scr_ok     = ok[CL_SCR];
    bus.obj_data   = data[CL_OBJ];
    bus.obj_ok     = ok[CL_OBJ];
  end
endmodule

// File: tb/tb_jtkiwi_gfxrom.sv
// tb_jtkiwi_gfxrom: directed, table-driven bench for jtkiwi_gfxrom.
module tb_jtkiwi_gfxrom;
  logic clk, rst;
  int   n_cmp = 0, n_bad = 0;

  jtkiwi_gfxrom_if bus();
  jtkiwi_gfxrom dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        scs;
    logic [17:0] sa;
    logic        ocs;
    logic [17:0] oa;
    logic        sok;
    logic        ook;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input logic [20:0] exp_addr);
    for (int i = 0; i < 20 && !bus.sdram_req; i++) step();
    chk("req_seen", {31'd0, bus.sdram_req}, 32'd1);
    chk("req_addr", {11'd0, bus.sdram_addr}, {11'd0, exp_addr});
  endtask

  task automatic grant();
    repeat (3) step();
    chk("req_held", {31'd0, bus.sdram_req}, 32'd1);
    bus.sdram_gnt = 1'b1;
    step();
    bus.sdram_gnt = 1'b0;
    chk("req_drop", {31'd0, bus.sdram_req}, 32'd0);
  endtask

  task automatic beat(input logic [15:0] d);
    bus.sdram_rdy = 1'b1;
    bus.sdram_din = d;
    step();
    bus.sdram_rdy = 1'b0;
  endtask

  task automatic fetch(input logic [20:0] a, input logic [15:0] d0, input logic [15:0] d1);
    wait_req(a);
    grant();
    beat(d0);
    beat(d1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_scr_data"}, bus.scr_data, 32'd0);
    chk({nm, "_scr_ok"}, {31'd0, bus.scr_ok}, 32'd0);
    chk({nm, "_obj_data"}, bus.obj_data, 32'd0);
    chk({nm, "_obj_ok"}, {31'd0, bus.obj_ok}, 32'd0);
    chk({nm, "_req"}, {31'd0, bus.sdram_req}, 32'd0);
    chk({nm, "_saddr"}, {11'd0, bus.sdram_addr}, 32'd0);
  endtask

  initial begin
    vec_t vt[6];
    vt[0] = '{1'b1, 18'h10, 1'b1, 18'h4,  1'b1, 1'b1};
    vt[1] = '{1'b0, 18'h10, 1'b1, 18'h4,  1'b0, 1'b1};
    vt[2] = '{1'b0, 18'h99, 1'b0, 18'h77, 1'b0, 1'b0};
    vt[3] = '{1'b1, 18'h10, 1'b0, 18'h4,  1'b1, 1'b0};
    vt[4] = '{1'b0, 18'h10, 1'b1, 18'h4,  1'b0, 1'b1};
    vt[5] = '{1'b1, 18'h10, 1'b1, 18'h4,  1'b1, 1'b1};

    rst = 1'b1;
    bus.scr_addr = '0; bus.scr_cs = 1'b0;
    bus.obj_addr = '0; bus.obj_cs = 1'b0;
    bus.sdram_gnt = 1'b0; bus.sdram_rdy = 1'b0; bus.sdram_din = '0;
    repeat (3) step();
    chk_zero("reset");
    rst = 1'b0;
    step();

`ifdef JTKIWI_GFXROM_PREFETCH_EN
    bus.scr_cs = 1'b1; bus.scr_addr = 18'h10;
    fetch(21'h00020, 16'h1234, 16'hABCD);
    chk("pf_fill_ok", {31'd0, bus.scr_ok}, 32'd1);
    fetch(21'h00022, 16'h5678, 16'h1111);
    chk("pf_main_ok", {31'd0, bus.scr_ok}, 32'd1);
    chk("pf_main_data", bus.scr_data, 32'hABCD1234);
    bus.scr_addr = 18'h11;
    step();
    chk("pf_hit_ok", {31'd0, bus.scr_ok}, 32'd1);
    chk("pf_hit_data", bus.scr_data, 32'h11115678);
    chk("pf_hit_noreq", {31'd0, bus.sdram_req}, 32'd0);
    repeat (3) step();
    chk("pf_quiet", {31'd0, bus.sdram_req}, 32'd0);
`else
    // Basic miss then hit
    bus.scr_cs = 1'b1; bus.scr_addr = 18'h10;
    fetch(21'h00020, 16'h1234, 16'hABCD);
    chk("t1_ok", {31'd0, bus.scr_ok}, 32'd1);
    chk("t1_data", bus.scr_data, 32'hABCD1234);
    step();
    chk("t2_hold_ok", {31'd0, bus.scr_ok}, 32'd1);
    bus.scr_cs = 1'b0; bus.scr_addr = 18'h11;
    step();
    chk("t2_away_ok", {31'd0, bus.scr_ok}, 32'd0);
    bus.scr_cs = 1'b1; bus.scr_addr = 18'h10;
    step();
    chk("t2_back_ok", {31'd0, bus.scr_ok}, 32'd1);
    chk("t2_back_noreq", {31'd0, bus.sdram_req}, 32'd0);

    // Simultaneous misses from an empty cache
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t3_rst_ok", {31'd0, bus.scr_ok}, 32'd0);
    bus.obj_cs = 1'b1; bus.obj_addr = 18'h4;
    step();
    chk("t3_first", {11'd0, bus.sdram_addr}, 32'h00020);
    fetch(21'h00020, 16'h1234, 16'hABCD);
    chk("t3_scr_ok", {31'd0, bus.scr_ok}, 32'd1);
    chk("t3_obj_wait", {31'd0, bus.obj_ok}, 32'd0);
    chk("t3_obj_untouched", bus.obj_data, 32'd0);
    fetch(21'h80008, 16'h7788, 16'h5566);
    chk("t3_obj_ok", {31'd0, bus.obj_ok}, 32'd1);
    chk("t3_obj_data", bus.obj_data, 32'h55667788);
    chk("t3_scr_keep", bus.scr_data, 32'hABCD1234);

    // Hit/idle table
    for (int i = 0; i < 6; i++) begin
      bus.scr_cs = vt[i].scs; bus.scr_addr = vt[i].sa;
      bus.obj_cs = vt[i].ocs; bus.obj_addr = vt[i].oa;
      step();
      chk($sformatf("vec%0d_scr_ok", i), {31'd0, bus.scr_ok}, {31'd0, vt[i].sok});
      chk($sformatf("vec%0d_obj_ok", i), {31'd0, bus.obj_ok}, {31'd0, vt[i].ook});
      chk($sformatf("vec%0d_req", i), {31'd0, bus.sdram_req}, 32'd0);
      chk($sformatf("vec%0d_scr_data", i), bus.scr_data, 32'hABCD1234);
      chk($sformatf("vec%0d_obj_data", i), bus.obj_data, 32'h55667788);
    end

    // Stray gnt/rdy in IDLE
    bus.sdram_gnt = 1'b1; bus.sdram_rdy = 1'b1; bus.sdram_din = 16'hFFFF;
    repeat (2) step();
    bus.sdram_gnt = 1'b0; bus.sdram_rdy = 1'b0;
    step();
    chk("stray_req", {31'd0, bus.sdram_req}, 32'd0);
    chk("stray_data", bus.scr_data, 32'hABCD1234);
    chk("stray_ok", {31'd0, bus.scr_ok}, 32'd1);

    // Second double miss: fairness now favours obj
    bus.scr_addr = 18'h30; bus.obj_addr = 18'h8;
    step();
    chk("t4_obj_first", {11'd0, bus.sdram_addr}, 32'h80010);
    fetch(21'h80010, 16'h0002, 16'h0001);
    chk("t4_obj_ok", {31'd0, bus.obj_ok}, 32'd1);
    fetch(21'h00060, 16'h0004, 16'h0003);
    chk("t4_scr_ok", {31'd0, bus.scr_ok}, 32'd1);
    chk("t4_scr_data", bus.scr_data, 32'h00030004);

    // Address change mid-fetch
    bus.obj_cs = 1'b0;
    bus.scr_addr = 18'h10;
    wait_req(21'h00020);
    grant();
    bus.scr_addr = 18'h11;
    beat(16'h2222);
    beat(16'h1111);
    chk("t5_stale_ok", {31'd0, bus.scr_ok}, 32'd0);
    chk("t5_stale_data", bus.scr_data, 32'h11112222);
    fetch(21'h00022, 16'h4444, 16'h3333);
    chk("t5_ok", {31'd0, bus.scr_ok}, 32'd1);
    chk("t5_data", bus.scr_data, 32'h33334444);

    // Reset during BEAT1
    bus.scr_addr = 18'h50;
    wait_req(21'h000A0);
    grant();
    beat(16'h6666);
    #2 rst = 1'b1;
    #1;
    chk_zero("t6_async");
    step();
    rst = 1'b0;
    bus.sdram_rdy = 1'b1; bus.sdram_din = 16'h7777;
    step();
    bus.sdram_rdy = 1'b0;
    chk("t6_rdy_ignored_ok", {31'd0, bus.scr_ok}, 32'd0);
    chk("t6_rdy_ignored_data", bus.scr_data, 32'd0);
    fetch(21'h000A0, 16'h9999, 16'h8888);
    chk("t6_ok", {31'd0, bus.scr_ok}, 32'd1);
    chk("t6_data", bus.scr_data, 32'h88889999);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
